// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Contents:
//   reg_idx_t / fwd_sel_t : register-number and forwarding-select types
//   FWD_*                 : EX operand source encodings
//   sb_entry_t / SB_NOP   : scoreboard entry layout and the bubble (NOP) value
//   fwd_pick()            : youngest-first forwarding priority
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [FWD_W-1:0] fwd_sel_t;

    // EX operand sources
    localparam fwd_sel_t FWD_RF = 2'b00;  // register file
    localparam fwd_sel_t FWD_EM = 2'b01;  // RD_VAL_EM
    localparam fwd_sel_t FWD_MW = 2'b10;  // RD_VAL_MW
    localparam fwd_sel_t FWD_WB = 2'b11;  // WE_RD_VAL, written one cycle earlier

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
        logic     we;
        logic     ld;
    } sb_entry_t;

    // A bubble in DE is a NOP: IALU=0, RD=0, nothing written.
    localparam sb_entry_t SB_NOP = '{v: 1'b0, rd: '0, we: 1'b0, ld: 1'b0};

    // Youngest producer wins: DE occupant, then EM, then MW.
    function automatic fwd_sel_t fwd_pick(input logic hit_de, input logic hit_em,
                                          input logic hit_mw);
        if (hit_de) return FWD_EM;
        if (hit_em) return FWD_MW;
        if (hit_mw) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard query and pipeline control bundle.
//   master : pipeline side, drives the ID instruction info and EX redirect
//   slave  : hazard controller, returns stall/flush/bubble and forwarding selects
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic     id_valid;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    logic     id_use_rs1;
    logic     id_use_rs2;
    reg_idx_t id_rd;
    logic     id_we;
    logic     id_is_load;
    logic     ex_redirect;

    logic     stall_pc;
    logic     stall_fd;
    logic     bubble_de;
    logic     flush_fd;
    fwd_sel_t fwd_a_sel;
    fwd_sel_t fwd_b_sel;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        output ex_redirect,
        input  stall_pc, stall_fd, bubble_de, flush_fd, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        input  ex_redirect,
        output stall_pc, stall_fd, bubble_de, flush_fd, fwd_a_sel, fwd_b_sel
    );

endinterface

// File: rtl/hazard_ctrl_sb_entry.sv
// One scoreboard entry: registers a {v, rd, we, ld} record every clock and
// compares it against the two ID source registers.
//   i_clk, i_rstn      : clock, async active-low reset (entry goes invalid)
//   i_d                : next entry value
//   i_rs_a / i_use_a   : operand A source and "source is really read" qualifier
//   i_rs_b / i_use_b   : operand B likewise
//   o_q                : current entry (feeds the next-older stage)
//   o_hit_a / o_hit_b  : entry will write the register operand A / B reads
module hazard_ctrl_sb_entry
    import hazard_ctrl_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rstn,
    input  sb_entry_t i_d,
    input  reg_idx_t  i_rs_a,
    input  logic      i_use_a,
    input  reg_idx_t  i_rs_b,
    input  logic      i_use_b,
    output sb_entry_t o_q,
    output logic      o_hit_a,
    output logic      o_hit_b
);

    sb_entry_t r_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_q <= SB_NOP;
        end else begin
            r_q <= i_d;
        end
    end

    // x0 is hardwired, so it never matches regardless of what is in flight.
    assign o_hit_a = i_use_a & r_q.v & r_q.we & (r_q.rd == i_rs_a) & (i_rs_a != '0);
    assign o_hit_b = i_use_b & r_q.v & r_q.we & (r_q.rd == i_rs_b) & (i_rs_b != '0);
    assign o_q     = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage RV32I pipeline.
// Tracks destination registers in flight in DE/EM/MW and from that drives
// PC/FD stalls, the DE bubble, the FD flush, registered EX forwarding selects
// and saturating stall/flush event counters.
//   i_clk, i_rstn : clock, async active-low reset
//   hz            : ID query / pipeline control bundle (slave side)
//   o_stall_cnt   : cycles stalled on a data hazard (saturating)
//   o_flush_cnt   : EX redirect cycles (saturating)
// FWD_EN = 0 builds an interlock-only variant: stall until the producer has
// left MW, forwarding selects stay at the register file.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t w_sb_in;
    sb_entry_t w_sb_de;
    sb_entry_t w_sb_em;
    sb_entry_t w_sb_mw;

    logic w_use_a;
    logic w_use_b;
    logic w_hit_a_de, w_hit_b_de;
    logic w_hit_a_em, w_hit_b_em;
    logic w_hit_a_mw, w_hit_b_mw;
    logic w_lu_de;
    logic w_lu_any;
    logic w_lu;
    logic w_stall_pc;
    logic w_stall_fd;
    logic w_bubble;
    logic w_flush_fd;
    logic w_unused_mw;

    fwd_sel_t         r_fwd_a;
    fwd_sel_t         r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_use_a = hz.id_valid & hz.id_use_rs1;
    assign w_use_b = hz.id_valid & hz.id_use_rs2;

    // Next DE entry: the ID instruction, or a NOP when it is held back/killed.
    always_comb begin
        w_sb_in = SB_NOP;
        if (!w_bubble) begin
            w_sb_in.v  = hz.id_valid & hz.id_we & (hz.id_rd != '0);
            w_sb_in.rd = hz.id_rd;
            w_sb_in.we = hz.id_we;
            w_sb_in.ld = hz.id_is_load;
        end
    end

    hazard_ctrl_sb_entry u_sb_de (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_d     (w_sb_in),
        .i_rs_a  (hz.id_rs1),
        .i_use_a (w_use_a),
        .i_rs_b  (hz.id_rs2),
        .i_use_b (w_use_b),
        .o_q     (w_sb_de),
        .o_hit_a (w_hit_a_de),
        .o_hit_b (w_hit_b_de)
    );

    hazard_ctrl_sb_entry u_sb_em (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_d     (w_sb_de),
        .i_rs_a  (hz.id_rs1),
        .i_use_a (w_use_a),
        .i_rs_b  (hz.id_rs2),
        .i_use_b (w_use_b),
        .o_q     (w_sb_em),
        .o_hit_a (w_hit_a_em),
        .o_hit_b (w_hit_b_em)
    );

    hazard_ctrl_sb_entry u_sb_mw (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_d     (w_sb_em),
        .i_rs_a  (hz.id_rs1),
        .i_use_a (w_use_a),
        .i_rs_b  (hz.id_rs2),
        .i_use_b (w_use_b),
        .o_q     (w_sb_mw),
        .o_hit_a (w_hit_a_mw),
        .o_hit_b (w_hit_b_mw)
    );

    // The oldest entry retires after MW; only its match outputs matter.
    assign w_unused_mw = ^w_sb_mw;

    // With forwarding, only a load still in DE cannot be bypassed in time.
    assign w_lu_de  = (w_hit_a_de | w_hit_b_de) & w_sb_de.ld;
    assign w_lu_any = w_hit_a_de | w_hit_b_de | w_hit_a_em | w_hit_b_em |
                      w_hit_a_mw | w_hit_b_mw;
    assign w_lu     = FWD_EN ? w_lu_de : w_lu_any;

    // A redirect beats a stall: the stalled instruction is on the wrong path.
    always_comb begin
        w_stall_pc = 1'b0;
        w_stall_fd = 1'b0;
        w_bubble   = 1'b0;
        w_flush_fd = 1'b0;
        if (hz.ex_redirect) begin
            w_flush_fd = 1'b1;
            w_bubble   = 1'b1;
        end else if (w_lu) begin
            w_stall_pc = 1'b1;
            w_stall_fd = 1'b1;
            w_bubble   = 1'b1;
        end
    end

    // Selects are captured as the consumer enters DE so they hold for its EX cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (!FWD_EN || w_bubble) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= fwd_pick(w_hit_a_de, w_hit_a_em, w_hit_a_mw);
            r_fwd_b <= fwd_pick(w_hit_b_de, w_hit_b_em, w_hit_b_mw);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lu && !hz.ex_redirect && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (hz.ex_redirect && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.stall_pc  = w_stall_pc;
    assign hz.stall_fd  = w_stall_fd;
    assign hz.bubble_de = w_bubble;
    assign hz.flush_fd  = w_flush_fd;
    assign hz.fwd_a_sel = r_fwd_a;
    assign hz.fwd_b_sel = r_fwd_b;
    assign o_stall_cnt  = r_stall_cnt;
    assign o_flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance (32-bit counters) and an
// interlock-only instance (3-bit counters) see identical stimulus. Each cycle
// a pipeline model pushes expected outputs into a queue that is popped and
// compared at the falling edge; directed checks cover the scenarios of interest.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CW1 = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if if0 ();
    hazard_ctrl_if if1 ();

    logic [31:0]    sc0, fc0;
    logic [CW1-1:0] sc1, fc1;

    hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) u_dut0 (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .hz          (if0),
        .o_stall_cnt (sc0),
        .o_flush_cnt (fc0)
    );

    hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(CW1)) u_dut1 (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .hz          (if1),
        .o_stall_cnt (sc1),
        .o_flush_cnt (fc1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus copies ----------------
    logic     in_v, in_u1, in_u2, in_we, in_ld, in_rdr;
    reg_idx_t in_rs1, in_rs2, in_rd;

    // ---------------- pipeline model, index [dut][stage: 0=DE 1=EM 2=MW] -----------
    bit       m_v  [2][3];
    bit       m_we [2][3];
    bit       m_ld [2][3];
    reg_idx_t m_rd [2][3];
    fwd_sel_t m_fa [2];
    fwd_sel_t m_fb [2];
    longint   m_sc [2];
    longint   m_fc [2];
    longint   m_max[2] = '{64'h0000_0000_FFFF_FFFF, 64'd7};

    typedef struct {
        int       d;
        logic     spc, sfd, bub, ffd;
        fwd_sel_t fa, fb;
        longint   sc, fc;
    } exp_t;
    exp_t q[$];

    logic obs_spc0, obs_bub0, obs_ffd0, obs_spc1;

    function automatic void mdl_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 3; s++) begin
                m_v[d][s] = 0; m_we[d][s] = 0; m_ld[d][s] = 0; m_rd[d][s] = '0;
            end
            m_fa[d] = 2'b00; m_fb[d] = 2'b00; m_sc[d] = 0; m_fc[d] = 0;
        end
    endfunction

    function automatic bit mhit(input int d, input int s, input reg_idx_t r, input bit used);
        return used && m_v[d][s] && m_we[d][s] && (m_rd[d][s] == r) && (r != 0);
    endfunction

    function automatic bit mdl_lu(input int d);
        bit ua = in_v & in_u1;
        bit ub = in_v & in_u2;
        bit lu = 0;
        if (d == 0) begin
            lu = (mhit(0, 0, in_rs1, ua) || mhit(0, 0, in_rs2, ub)) && m_ld[0][0];
        end else begin
            for (int s = 0; s < 3; s++)
                if (mhit(1, s, in_rs1, ua) || mhit(1, s, in_rs2, ub)) lu = 1;
        end
        return lu;
    endfunction

    function automatic exp_t mdl_expect(input int d);
        exp_t e;
        bit lu = mdl_lu(d);
        e.d   = d;
        e.ffd = in_rdr;
        e.bub = in_rdr | lu;
        e.spc = !in_rdr && lu;
        e.sfd = !in_rdr && lu;
        e.fa  = m_fa[d];
        e.fb  = m_fb[d];
        e.sc  = m_sc[d];
        e.fc  = m_fc[d];
        return e;
    endfunction

    function automatic fwd_sel_t mdl_sel(input int d, input reg_idx_t r, input bit used);
        for (int s = 0; s < 3; s++)
            if (mhit(d, s, r, used)) return fwd_sel_t'(s + 1);
        return 2'b00;
    endfunction

    function automatic void mdl_clock(input int d);
        bit lu  = mdl_lu(d);
        bit bub = in_rdr | lu;
        if (lu && !in_rdr && m_sc[d] < m_max[d]) m_sc[d]++;
        if (in_rdr && m_fc[d] < m_max[d]) m_fc[d]++;
        if (d == 0 && !bub) begin
            m_fa[d] = mdl_sel(d, in_rs1, in_v & in_u1);
            m_fb[d] = mdl_sel(d, in_rs2, in_v & in_u2);
        end else begin
            m_fa[d] = 2'b00;
            m_fb[d] = 2'b00;
        end
        for (int s = 2; s > 0; s--) begin
            m_v[d][s] = m_v[d][s-1]; m_we[d][s] = m_we[d][s-1];
            m_ld[d][s] = m_ld[d][s-1]; m_rd[d][s] = m_rd[d][s-1];
        end
        m_v[d][0]  = !bub && in_v && in_we && (in_rd != 0);
        m_we[d][0] = !bub && in_we;
        m_ld[d][0] = !bub && in_ld;
        m_rd[d][0] = bub ? 5'd0 : in_rd;
    endfunction

    // ---------------- drive / compare ----------------
    task automatic drive(input logic v, input reg_idx_t rs1, input logic u1,
                         input reg_idx_t rs2, input logic u2, input reg_idx_t rd,
                         input logic we, input logic ld, input logic rdr);
        in_v = v; in_rs1 = rs1; in_u1 = u1; in_rs2 = rs2; in_u2 = u2;
        in_rd = rd; in_we = we; in_ld = ld; in_rdr = rdr;
        if0.id_valid = v;  if0.id_rs1 = rs1; if0.id_use_rs1 = u1; if0.id_rs2 = rs2;
        if0.id_use_rs2 = u2; if0.id_rd = rd; if0.id_we = we; if0.id_is_load = ld;
        if0.ex_redirect = rdr;
        if1.id_valid = v;  if1.id_rs1 = rs1; if1.id_use_rs1 = u1; if1.id_rs2 = rs2;
        if1.id_use_rs2 = u2; if1.id_rd = rd; if1.id_we = we; if1.id_is_load = ld;
        if1.ex_redirect = rdr;
    endtask

    task automatic sb_compare();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.d == 0) begin
                check("d0 stall_pc",  32'(if0.stall_pc),  32'(e.spc));
                check("d0 stall_fd",  32'(if0.stall_fd),  32'(e.sfd));
                check("d0 bubble_de", 32'(if0.bubble_de), 32'(e.bub));
                check("d0 flush_fd",  32'(if0.flush_fd),  32'(e.ffd));
                check("d0 fwd_a",     32'(if0.fwd_a_sel), 32'(e.fa));
                check("d0 fwd_b",     32'(if0.fwd_b_sel), 32'(e.fb));
                check("d0 stall_cnt", sc0, e.sc[31:0]);
                check("d0 flush_cnt", fc0, e.fc[31:0]);
            end else begin
                check("d1 stall_pc",  32'(if1.stall_pc),  32'(e.spc));
                check("d1 stall_fd",  32'(if1.stall_fd),  32'(e.sfd));
                check("d1 bubble_de", 32'(if1.bubble_de), 32'(e.bub));
                check("d1 flush_fd",  32'(if1.flush_fd),  32'(e.ffd));
                check("d1 fwd_a",     32'(if1.fwd_a_sel), 32'(e.fa));
                check("d1 fwd_b",     32'(if1.fwd_b_sel), 32'(e.fb));
                check("d1 stall_cnt", 32'(sc1), e.sc[31:0]);
                check("d1 flush_cnt", 32'(fc1), e.fc[31:0]);
            end
        end
        obs_spc0 = if0.stall_pc;
        obs_bub0 = if0.bubble_de;
        obs_ffd0 = if0.flush_fd;
        obs_spc1 = if1.stall_pc;
    endtask

    task automatic step(input logic v, input reg_idx_t rs1, input logic u1,
                        input reg_idx_t rs2, input logic u2, input reg_idx_t rd,
                        input logic we, input logic ld, input logic rdr);
        drive(v, rs1, u1, rs2, u2, rd, we, ld, rdr);
        for (int d = 0; d < 2; d++) q.push_back(mdl_expect(d));
        @(negedge clk);
        sb_compare();
        for (int d = 0; d < 2; d++) mdl_clock(d);
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input reg_idx_t rd, input reg_idx_t rs1, input reg_idx_t rs2);
        step(1, rs1, 1, rs2, 1, rd, 1, 0, 0);
    endtask

    task automatic load(input reg_idx_t rd);
        step(1, 5'd2, 1, 5'd0, 0, rd, 1, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " d0 ctl"}, {28'd0, if0.stall_pc, if0.stall_fd, if0.bubble_de, if0.flush_fd}, 0);
        check({tag, " d0 fwd"}, {28'd0, if0.fwd_a_sel, if0.fwd_b_sel}, 0);
        check({tag, " d0 cnt"}, sc0 | fc0, 0);
        check({tag, " d1 ctl"}, {28'd0, if1.stall_pc, if1.stall_fd, if1.bubble_de, if1.flush_fd}, 0);
        check({tag, " d1 fwd"}, {28'd0, if1.fwd_a_sel, if1.fwd_b_sel}, 0);
        check({tag, " d1 cnt"}, 32'(sc1 | fc1), 0);
    endtask

    int n_st;

    initial begin
        mdl_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back ALU dependency: forwarded from EM, no stall.
        alu(5'd1, 5'd2, 5'd3);
        alu(5'd4, 5'd1, 5'd5);
        check("alu-alu no stall", 32'(obs_spc0), 0);
        check("alu-alu fwd_a", 32'(if0.fwd_a_sel), 32'(FWD_EM));
        check("alu-alu fwd_b", 32'(if0.fwd_b_sel), 32'(FWD_RF));
        idle(3);

        // Load-use: one stall cycle, then forward from MW.
        load(5'd6);
        alu(5'd7, 5'd6, 5'd6);
        check("ld-use stall", 32'({obs_spc0, obs_bub0}), 32'b11);
        alu(5'd7, 5'd6, 5'd6);
        check("ld-use released", 32'(obs_spc0), 0);
        check("ld-use fwd_a", 32'(if0.fwd_a_sel), 32'(FWD_MW));
        check("ld-use fwd_b", 32'(if0.fwd_b_sel), 32'(FWD_MW));
        check("ld-use stall_cnt", sc0, 1);
        idle(3);

        // Producer three ahead: WB-value forward; then youngest-wins.
        alu(5'd8, 5'd2, 5'd3);
        alu(5'd9, 5'd2, 5'd3);
        alu(5'd10, 5'd2, 5'd3);
        alu(5'd11, 5'd8, 5'd3);
        check("wb fwd_a", 32'(if0.fwd_a_sel), 32'(FWD_WB));
        alu(5'd8, 5'd2, 5'd3);
        alu(5'd8, 5'd2, 5'd3);
        alu(5'd12, 5'd8, 5'd8);
        check("youngest fwd_a", 32'(if0.fwd_a_sel), 32'(FWD_EM));
        check("youngest fwd_b", 32'(if0.fwd_b_sel), 32'(FWD_EM));
        idle(3);

        // x0 never matches; a non-writing producer never matches.
        step(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0);
        alu(5'd13, 5'd0, 5'd0);
        check("x0 no stall", 32'(obs_spc0), 0);
        check("x0 fwd", 32'({if0.fwd_a_sel, if0.fwd_b_sel}), 0);
        step(1, 5'd2, 1, 5'd0, 0, 5'd14, 0, 1, 0);
        alu(5'd15, 5'd14, 5'd14);
        check("we=0 no stall", 32'(obs_spc0), 0);
        check("we=0 fwd", 32'({if0.fwd_a_sel, if0.fwd_b_sel}), 0);
        idle(3);

        // Redirect coincident with load-use: flush wins.
        load(5'd16);
        step(1, 5'd16, 1, 5'd0, 0, 5'd17, 1, 0, 1);
        check("redir ctl", 32'({obs_ffd0, obs_bub0, obs_spc0}), 32'b110);
        check("redir flush_cnt", fc0, 1);
        check("redir stall_cnt", sc0, 1);
        idle(3);

        // Interlock-only instance: three stall cycles, never forwards.
        alu(5'd1, 5'd2, 5'd3);
        n_st = 0;
        for (int i = 0; i < 4; i++) begin
            alu(5'd18, 5'd1, 5'd0);
            if (obs_spc1) n_st++;
            check("nofwd fwd", 32'({if1.fwd_a_sel, if1.fwd_b_sel}), 0);
        end
        check("nofwd stall cycles", n_st, 3);
        idle(3);

        // Asynchronous reset in the middle of a stall.
        alu(5'd1, 5'd2, 5'd3);
        drive(1, 5'd1, 1, 5'd0, 0, 5'd18, 1, 0, 0);
        #1;
        check("pre-reset stall", 32'(if1.stall_pc), 1);
        rstn = 1'b0;
        #1;
        check_all_zero("async reset");
        mdl_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Saturation of the 3-bit counters (9 events each).
        for (int k = 0; k < 3; k++) begin
            alu(5'd1, 5'd2, 5'd3);
            for (int i = 0; i < 3; i++) alu(5'd18, 5'd1, 5'd0);
        end
        check("sat stall_cnt d1", 32'(sc1), 7);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("sat flush_cnt d1", 32'(fc1), 7);
        check("flush_cnt d0", fc0, 9);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
